// File: rtl/exp6_condiciona_botoes.sv
// -----------------------------------------------------------------------------
// exp6_condiciona_botoes
//
// Push-button conditioning stage placed in front of the memory-game top.
// Each raw button line is brought into the clock domain through a 2-flop
// synchroniser and then debounced by its own 4-state FSM and counter. The
// stage produces the clean debounced levels, a one-cycle pulse on each
// debounced press, and a strobe that marks a press while exactly one button
// is held.
//
// Parameters
//   N_BOTOES         number of button lines
//   DEBOUNCE_CICLOS  consecutive stable cycles needed to accept a new level
//                    (must be >= 2; 50000 = 1 ms at 50 MHz)
//
// Ports
//   clock          system clock, all state on the rising edge
//   reset          asynchronous reset, active-low (0 = reset)
//   botoes_in      raw asynchronous button levels, 1 = pressed
//   botoes         debounced levels (registered)
//   pulso          one-cycle pulse per debounced rising edge
//   jogada_valida  one-cycle strobe: a press occurred and exactly one
//                  debounced button is high
//   multiplos      level: more than one debounced button is high
//   db_instavel    1 while the corresponding debounce counter is running
// -----------------------------------------------------------------------------
module exp6_condiciona_botoes #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_in,
  output logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] pulso,
  output logic                jogada_valida,
  output logic                multiplos,
  output logic [N_BOTOES-1:0] db_instavel
);

  // Derived widths: debounce counter and button popcount.
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int PW = $clog2(N_BOTOES + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    ESTAVEL_0  = 2'd0,  // settled released
    CONFIRMA_1 = 2'd1,  // candidate press, counting stable samples
    ESTAVEL_1  = 2'd2,  // settled pressed
    CONFIRMA_0 = 2'd3   // candidate release, counting stable samples
  } estado_t;

  // ---------------------------------------------------------------------------
  // Synchroniser: two flops per line, r_sync2 is the usable sample s[i].
  // ---------------------------------------------------------------------------
  logic [N_BOTOES-1:0] r_sync1;
  logic [N_BOTOES-1:0] r_sync2;

  // NOTE: state is updated only with non-blocking assignments inside an
  // always_ff that lists the reset edge, so every flop clears the moment
  // reset falls instead of waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= botoes_in;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-line debounce FSM: state register.
  // ---------------------------------------------------------------------------
  estado_t       r_estado      [N_BOTOES];
  estado_t       w_estado_prox [N_BOTOES];
  logic [CW-1:0] r_cont        [N_BOTOES];
  logic [CW-1:0] w_cont_prox   [N_BOTOES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BOTOES; i++) begin
        r_estado[i] <= ESTAVEL_0;
        r_cont[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BOTOES; i++) begin
        r_estado[i] <= w_estado_prox[i];
        r_cont[i]   <= w_cont_prox[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-line debounce FSM: next state and counter.
  // The counter holds the number of consecutive samples that already agree
  // with the candidate level. It is cleared on any reversal and the FSM leaves
  // the CONFIRMA_* state when it reaches DEBOUNCE_CICLOS-1, so it never wraps.
  // ---------------------------------------------------------------------------
  logic [N_BOTOES-1:0] w_nivel;  // debounced level decoded from the state

  always_comb begin
    for (int i = 0; i < N_BOTOES; i++) begin
      // NOTE: every output of this block gets a default before the case so
      // no path leaves a value unassigned and no latch is inferred.
      w_estado_prox[i] = r_estado[i];
      w_cont_prox[i]   = r_cont[i];
      w_nivel[i]       = 1'b0;
      db_instavel[i]   = 1'b0;

      case (r_estado[i])
        ESTAVEL_0: begin
          if (r_sync2[i]) begin
            w_estado_prox[i] = CONFIRMA_1;
            w_cont_prox[i]   = CNT_ONE;
          end else begin
            w_cont_prox[i]   = '0;
          end
        end

        CONFIRMA_1: begin
          db_instavel[i] = 1'b1;
          if (!r_sync2[i]) begin
            // Glitch: fall back and restart from zero.
            w_estado_prox[i] = ESTAVEL_0;
            w_cont_prox[i]   = '0;
          end else if (r_cont[i] == CNT_LAST) begin
            w_estado_prox[i] = ESTAVEL_1;
            w_cont_prox[i]   = '0;
          end else begin
            w_cont_prox[i]   = r_cont[i] + CNT_ONE;
          end
        end

        ESTAVEL_1: begin
          w_nivel[i] = 1'b1;
          if (!r_sync2[i]) begin
            w_estado_prox[i] = CONFIRMA_0;
            w_cont_prox[i]   = CNT_ONE;
          end else begin
            w_cont_prox[i]   = '0;
          end
        end

        CONFIRMA_0: begin
          // Still reported as pressed until the release is confirmed.
          w_nivel[i]     = 1'b1;
          db_instavel[i] = 1'b1;
          if (r_sync2[i]) begin
            w_estado_prox[i] = ESTAVEL_1;
            w_cont_prox[i]   = '0;
          end else if (r_cont[i] == CNT_LAST) begin
            w_estado_prox[i] = ESTAVEL_0;
            w_cont_prox[i]   = '0;
          end else begin
            w_cont_prox[i]   = r_cont[i] + CNT_ONE;
          end
        end

        default: begin
          w_estado_prox[i] = ESTAVEL_0;
          w_cont_prox[i]   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: levels, press pulses and press qualification.
  // Everything here is registered from the FSM state, so the outputs carry no
  // combinational path from botoes_in and pulso/jogada_valida line up with
  // the edge on which botoes first shows the new level.
  // ---------------------------------------------------------------------------
  logic [N_BOTOES-1:0] r_botoes;
  logic [N_BOTOES-1:0] r_pulso;
  logic                r_jogada_valida;
  logic                r_multiplos;

  logic [N_BOTOES-1:0] w_pulso_prox;
  logic [PW-1:0]       w_pop;

  always_comb begin
    w_pulso_prox = w_nivel & ~r_botoes;
    w_pop        = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      w_pop = w_pop + PW'(w_nivel[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_botoes        <= '0;
      r_pulso         <= '0;
      r_jogada_valida <= 1'b0;
      r_multiplos     <= 1'b0;
    end else begin
      r_botoes        <= w_nivel;
      r_pulso         <= w_pulso_prox;
      // Popcount is taken on the new level vector, so a press while another
      // button is held is not a valid move.
      r_jogada_valida <= (|w_pulso_prox) && (w_pop == PW'(1));
      r_multiplos     <= (w_pop > PW'(1));
    end
  end

  assign botoes        = r_botoes;
  assign pulso         = r_pulso;
  assign jogada_valida = r_jogada_valida;
  assign multiplos     = r_multiplos;

endmodule

// File: tb/tb_exp6_condiciona_botoes.sv
// -----------------------------------------------------------------------------
// tb_exp6_condiciona_botoes
//
// Self-checking bench for exp6_condiciona_botoes with DEBOUNCE_CICLOS=4 and
// N_BOTOES=4. Each scenario task builds a per-edge stimulus list, pushes the
// expected output snapshots (keyed by edge number) into a scoreboard queue,
// then drives the stimulus and pops/compares entries as their edge arrives.
// Edge 0 is the first rising edge that samples a scenario's first stimulus.
// -----------------------------------------------------------------------------
module tb_exp6_condiciona_botoes;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] botoes_in = '0;
  logic [N-1:0] botoes;
  logic [N-1:0] pulso;
  logic         jogada_valida;
  logic         multiplos;
  logic [N-1:0] db_instavel;

  exp6_condiciona_botoes #(
    .N_BOTOES        (N),
    .DEBOUNCE_CICLOS (DB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes_in     (botoes_in),
    .botoes        (botoes),
    .pulso         (pulso),
    .jogada_valida (jogada_valida),
    .multiplos     (multiplos),
    .db_instavel   (db_instavel)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] b;     // botoes
    logic [3:0] p;     // pulso
    logic       jv;    // jogada_valida
    logic       m;     // multiplos
    logic [3:0] inst;  // db_instavel
  } obs_t;

  typedef struct packed {
    logic [15:0] edge_n;
    obs_t        v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t sample();
    obs_t o;
    o = {botoes, pulso, jogada_valida, multiplos, db_instavel};
    return o;
  endfunction

  function automatic void expect_at(int e, logic [3:0] b, logic [3:0] p,
                                    logic jv, logic m, logic [3:0] inst);
    exp_t x;
    x.edge_n = 16'(e);
    x.v      = {b, p, jv, m, inst};
    sb.push_back(x);
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    obs_t o;
    reset     = 1'b0;
    botoes_in = 4'b1111;
    #3;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0))
      $display("FAIL reset_initial: got %b required %b", o, obs_t'(0));
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      o = sample();
      n_checks++;
      if (o !== obs_t'(0))
        $display("FAIL reset_held cycle %0d: got %b required %b", k, o, obs_t'(0));
      else n_pass++;
    end
    botoes_in = 4'b0000;
    #2 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      o = sample();
      n_checks++;
      if (o !== obs_t'(0))
        $display("FAIL reset_release_idle cycle %0d: got %b required %b", k, o, obs_t'(0));
      else n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_clean_press();
    logic [3:0] stim[$];
    obs_t o;
    exp_t x;
    for (int e = 0; e < 20; e++) stim.push_back(e < 10 ? 4'b0010 : 4'b0000);
    expect_at( 1, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at( 2, 4'b0000, 4'b0000, 0, 0, 4'b0010);
    expect_at( 4, 4'b0000, 4'b0000, 0, 0, 4'b0010);
    expect_at( 5, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at( 6, 4'b0010, 4'b0010, 1, 0, 4'b0000);
    expect_at( 7, 4'b0010, 4'b0000, 0, 0, 4'b0000);
    expect_at(14, 4'b0010, 4'b0000, 0, 0, 4'b0010);
    expect_at(15, 4'b0010, 4'b0000, 0, 0, 4'b0000);
    expect_at(16, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at(17, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int e = 0; e < stim.size(); e++) begin
      botoes_in = stim[e];
      @(posedge clock); #1;
      o = sample();
      while (sb.size() > 0 && sb[0].edge_n == 16'(e)) begin
        x = sb.pop_front();
        n_checks++;
        if (o !== x.v) $display("FAIL clean_press edge %0d: got %b required %b", e, o, x.v);
        else n_pass++;
      end
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      $display("FAIL clean_press edge %0d never reached: required %b", x.edge_n, x.v);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bounce();
    logic [3:0] stim[$];
    logic [3:0] pat;
    obs_t o;
    exp_t x;
    int   n_pulses = 0;
    pat = 4'b0101;  // bounce on bit0 for edges 0..4: 1,0,1,0,1
    for (int e = 0; e < 22; e++) begin
      if (e < 5)       stim.push_back({3'b000, ~pat[e % 4] ^ 1'b1 ^ (e == 4 ? 1'b0 : 1'b0)});
      else if (e < 14) stim.push_back(4'b0001);
      else             stim.push_back(4'b0000);
    end
    expect_at( 2, 4'b0000, 4'b0000, 0, 0, 4'b0001);
    expect_at( 3, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at( 4, 4'b0000, 4'b0000, 0, 0, 4'b0001);
    expect_at( 5, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at( 7, 4'b0000, 4'b0000, 0, 0, 4'b0001);
    expect_at( 9, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at(10, 4'b0001, 4'b0001, 1, 0, 4'b0000);
    expect_at(11, 4'b0001, 4'b0000, 0, 0, 4'b0000);
    expect_at(19, 4'b0001, 4'b0000, 0, 0, 4'b0000);
    expect_at(20, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int e = 0; e < stim.size(); e++) begin
      botoes_in = stim[e];
      @(posedge clock); #1;
      o = sample();
      if (o.p[0]) n_pulses++;
      while (sb.size() > 0 && sb[0].edge_n == 16'(e)) begin
        x = sb.pop_front();
        n_checks++;
        if (o !== x.v) $display("FAIL bounce edge %0d: got %b required %b", e, o, x.v);
        else n_pass++;
      end
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      $display("FAIL bounce edge %0d never reached: required %b", x.edge_n, x.v);
    end
    n_checks++;
    if (n_pulses !== 1) $display("FAIL bounce_pulse_count: got %0d required 1", n_pulses);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_glitch();
    logic [3:0] stim[$];
    obs_t o;
    exp_t x;
    for (int e = 0; e < 10; e++) stim.push_back(e < 3 ? 4'b1000 : 4'b0000);
    for (int e = 0; e < 10; e++)
      expect_at(e, 4'b0000, 4'b0000, 0, 0, (e >= 2 && e <= 4) ? 4'b1000 : 4'b0000);
    for (int e = 0; e < stim.size(); e++) begin
      botoes_in = stim[e];
      @(posedge clock); #1;
      o = sample();
      while (sb.size() > 0 && sb[0].edge_n == 16'(e)) begin
        x = sb.pop_front();
        n_checks++;
        if (o !== x.v) $display("FAIL glitch edge %0d: got %b required %b", e, o, x.v);
        else n_pass++;
      end
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      $display("FAIL glitch edge %0d never reached: required %b", x.edge_n, x.v);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    logic [3:0] stim[$];
    obs_t o;
    exp_t x;
    for (int e = 0; e < 32; e++) begin
      if      (e < 8)  stim.push_back(4'b0101);
      else if (e < 16) stim.push_back(4'b0000);
      else if (e < 24) stim.push_back(4'b1000);
      else             stim.push_back(4'b0000);
    end
    expect_at( 5, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at( 6, 4'b0101, 4'b0101, 0, 1, 4'b0000);
    expect_at( 7, 4'b0101, 4'b0000, 0, 1, 4'b0000);
    expect_at(13, 4'b0101, 4'b0000, 0, 1, 4'b0000);
    expect_at(14, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at(22, 4'b1000, 4'b1000, 1, 0, 4'b0000);
    expect_at(23, 4'b1000, 4'b0000, 0, 0, 4'b0000);
    expect_at(30, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int e = 0; e < stim.size(); e++) begin
      botoes_in = stim[e];
      @(posedge clock); #1;
      o = sample();
      while (sb.size() > 0 && sb[0].edge_n == 16'(e)) begin
        x = sb.pop_front();
        n_checks++;
        if (o !== x.v) $display("FAIL simultaneous edge %0d: got %b required %b", e, o, x.v);
        else n_pass++;
      end
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      $display("FAIL simultaneous edge %0d never reached: required %b", x.edge_n, x.v);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overlap();
    logic [3:0] stim[$];
    obs_t o;
    exp_t x;
    for (int e = 0; e < 36; e++) begin
      if      (e < 8)  stim.push_back(4'b0001);
      else if (e < 18) stim.push_back(4'b0101);
      else if (e < 28) stim.push_back(4'b0001);
      else             stim.push_back(4'b0000);
    end
    expect_at( 6, 4'b0001, 4'b0001, 1, 0, 4'b0000);
    expect_at( 7, 4'b0001, 4'b0000, 0, 0, 4'b0000);
    expect_at(10, 4'b0001, 4'b0000, 0, 0, 4'b0100);
    expect_at(14, 4'b0101, 4'b0100, 0, 1, 4'b0000);
    expect_at(15, 4'b0101, 4'b0000, 0, 1, 4'b0000);
    expect_at(22, 4'b0101, 4'b0000, 0, 1, 4'b0100);
    expect_at(23, 4'b0101, 4'b0000, 0, 1, 4'b0000);
    expect_at(24, 4'b0001, 4'b0000, 0, 0, 4'b0000);
    expect_at(25, 4'b0001, 4'b0000, 0, 0, 4'b0000);
    expect_at(34, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int e = 0; e < stim.size(); e++) begin
      botoes_in = stim[e];
      @(posedge clock); #1;
      o = sample();
      while (sb.size() > 0 && sb[0].edge_n == 16'(e)) begin
        x = sb.pop_front();
        n_checks++;
        if (o !== x.v) $display("FAIL overlap edge %0d: got %b required %b", e, o, x.v);
        else n_pass++;
      end
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      $display("FAIL overlap edge %0d never reached: required %b", x.edge_n, x.v);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [3:0] stim[$];
    obs_t o;
    exp_t x;
    // Start a 0010 press and abort it while the counter is running.
    botoes_in = 4'b0010;
    for (int e = 0; e < 3; e++) begin
      @(posedge clock); #1;
    end
    o = sample();
    n_checks++;
    if (o.inst !== 4'b0010)
      $display("FAIL reset_mid_counting: got inst=%b required 0010", o.inst);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    o = sample();
    n_checks++;
    if (o !== obs_t'(0))
      $display("FAIL reset_mid_async: got %b required %b", o, obs_t'(0));
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      o = sample();
      n_checks++;
      if (o !== obs_t'(0))
        $display("FAIL reset_mid_held cycle %0d: got %b required %b", k, o, obs_t'(0));
      else n_pass++;
    end
    #2 reset = 1'b1;
    // Button still held: re-acceptance counts from the first edge after release.
    for (int e = 0; e < 16; e++) stim.push_back(e < 8 ? 4'b0010 : 4'b0000);
    expect_at(4, 4'b0000, 4'b0000, 0, 0, 4'b0010);
    expect_at(5, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    expect_at(6, 4'b0010, 4'b0010, 1, 0, 4'b0000);
    expect_at(7, 4'b0010, 4'b0000, 0, 0, 4'b0000);
    expect_at(14, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int e = 0; e < stim.size(); e++) begin
      botoes_in = stim[e];
      @(posedge clock); #1;
      o = sample();
      while (sb.size() > 0 && sb[0].edge_n == 16'(e)) begin
        x = sb.pop_front();
        n_checks++;
        if (o !== x.v) $display("FAIL reset_mid_reaccept edge %0d: got %b required %b", e, o, x.v);
        else n_pass++;
      end
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      $display("FAIL reset_mid_reaccept edge %0d never reached: required %b", x.edge_n, x.v);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_overlap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exp6_condiciona_botoes.md
Name: exp6_condiciona_botoes

Overview:
Input-conditioning stage that sits directly upstream of the memory-game top and drives its botoes input. It synchronises the raw push-button lines and debounces each one independently. It then produces clean levels, one-cycle press pulses and a single-press validity strobe. This keeps contact bounce from generating spurious jogada_feita events in the datapath.

Parameters:
N_BOTOES, 4, number of button lines.
DEBOUNCE_CICLOS, 50000, consecutive stable cycles needed to accept a level change (1 ms at 50 MHz); must be >= 2.
CW, $clog2(DEBOUNCE_CICLOS+1), debounce counter width (derived, not overridden).

Ports:
clock  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous reset, active-low (0 = reset).
botoes_in  input  N_BOTOES  raw, asynchronous button levels, 1 = pressed.
botoes  output  N_BOTOES  debounced levels; feeds the game's botoes input.
pulso  output  N_BOTOES  one-cycle pulse per debounced rising edge.
jogada_valida  output  1  one-cycle strobe: a press occurred and exactly one debounced button is high.
multiplos  output  1  level: more than one debounced button high.
db_instavel  output  N_BOTOES  1 while that line's debounce counter is running.

Behaviour:
- Reset (reset=0, asynchronous): sync flops, counters, FSM state, botoes, pulso, jogada_valida, multiplos and db_instavel all go to 0. Release is sampled on a clock edge, with no extra release synchroniser.
- Synchroniser: 2 flip-flops per line; s[i] is the second-stage output.
- Per-line FSM, four states:
  - ESTAVEL_0: botoes[i]=0, counter=0. If s[i]=1, go to CONFIRMA_1 with counter=1.
  - CONFIRMA_1: if s[i]=0, return to ESTAVEL_0 and clear the counter (glitch rejected). Else if counter=DEBOUNCE_CICLOS-1, go to ESTAVEL_1. Else increment the counter.
  - ESTAVEL_1: botoes[i]=1. If s[i]=0, go to CONFIRMA_0 with counter=1.
  - CONFIRMA_0: symmetric to CONFIRMA_1, returning to ESTAVEL_1 on s[i]=1 or completing to ESTAVEL_0.
- db_instavel[i] = 1 in the CONFIRMA_* states.
- Latency: if a level is held from the first edge that samples it, botoes[i] changes exactly 2+DEBOUNCE_CICLOS edges later.
- Any reversal before completion restarts the count from zero at the next differing sample. Bounce shorter than DEBOUNCE_CICLOS cycles never reaches botoes.
- botoes is registered, taken directly from the FSM state with no combinational path from botoes_in.
- pulso[i]: registered, high for exactly the one cycle in which botoes[i] first reads 1. No pulse on release.
- jogada_valida: registered and aligned with pulso. It is high when |pulso is set and the new botoes vector has popcount == 1.
- multiplos: registered, = (popcount(botoes) > 1), updated on the same edge as botoes.
- Simultaneous presses:
  - Two lines completing on the same edge give two pulso bits, jogada_valida=0 and multiplos=1.
  - A second press while one button is held gives pulso for the new line only, jogada_valida=0 and multiplos=1.
  - A press after all others are released is valid again.
- Lines are fully independent; a line bouncing does not affect the others' counters.
- Reset mid-debounce aborts the count. After release, a still-held button is re-accepted after 2+DEBOUNCE_CICLOS edges and produces a normal pulso and jogada_valida.
- Counter arithmetic is unsigned CW bits and never wraps, because it is cleared or the FSM exits at DEBOUNCE_CICLOS-1.

Test Plan:
- All benches use DEBOUNCE_CICLOS=4, N_BOTOES=4.
- Clean press: botoes_in=0010 held from edge 0.
  - At edge 6: botoes=0010, pulso=0010, jogada_valida=1.
  - At edge 7: pulso=0000, jogada_valida=0.
  - Release held 6+ cycles gives botoes=0000 with no pulse.
- Bounce: bit0 toggles 1,0,1,0,1 on single cycles, then is held high.
  - botoes stays 0 during the bounce.
  - Exactly one pulso[0] appears, 6 edges after the final stable-high sample.
- Glitch rejection: bit3 high for 3 cycles, then low.
  - botoes and pulso stay 0 throughout.
  - db_instavel[3] is 1 for 3 cycles, then 0.
- Simultaneous press: botoes_in=0101 in one cycle -> pulso=0101, jogada_valida=0, multiplos=1. After release of both, a single press 1000 -> jogada_valida=1, multiplos=0.
- Overlap: hold 0001 until accepted, then add 0100.
  - pulso=0100, jogada_valida=0, multiplos=1.
  - Releasing bit2 returns multiplos to 0 with no pulse.
- Reset mid-operation: assert reset=0 at cycle 3 of a 0010 press, for 2 cycles (asynchronous, between edges).
  - All outputs read 0 immediately.
  - With the button held, botoes=0010 and jogada_valida=1 appear 6 edges after release.
